// File: rtl/tdm_pkg.sv
// Shared constants, state type and helpers for the TDM link receiver.
package tdm_pkg;

    localparam int N_CANAIS = 8;
    localparam int W_DADO   = 4;
    localparam int W_ID     = 3;
    localparam int W_CONT   = 8;

    localparam logic [W_ID-1:0]     ID_ZERO    = {W_ID{1'b0}};
    localparam logic [W_ID-1:0]     ID_UM      = {{(W_ID-1){1'b0}}, 1'b1};
    localparam logic [N_CANAIS-1:0] NOVO_VAZIO = {N_CANAIS{1'b0}};
    localparam logic [N_CANAIS-1:0] NOVO_CHEIO = {N_CANAIS{1'b1}};
    localparam logic [W_CONT-1:0]   CONT_UM    = {{(W_CONT-1){1'b0}}, 1'b1};

    // IDLE: nothing received in the current frame; COLLECT: at least one channel in.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } estado_t;

    // One-hot select vector for a channel tag.
    function automatic logic [N_CANAIS-1:0] id_onehot(input logic [W_ID-1:0] id);
        return {{(N_CANAIS-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/tdm_canal_reg.sv
// One output channel register: holds its nibble until an accepted write targets it.
module tdm_canal_reg
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [W_DADO-1:0] d,
    output logic [W_DADO-1:0] q
);

    logic [W_DADO-1:0] q_r;

    // Capture the link nibble only when this channel is the target of an accepted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= {W_DADO{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/tdm_demux.sv
// Receiver for the 8-channel 4-bit TDM link: routes tagged nibbles into eight
// stable channel registers and tracks frame completion, ordering errors and overruns.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter bit SEQ_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W_DADO-1:0] ENTRADA,
    input  logic [W_ID-1:0]   ID,
    input  logic              VALID,
    input  logic              CLR_ERRO,
    output logic [W_DADO-1:0] S0,
    output logic [W_DADO-1:0] S1,
    output logic [W_DADO-1:0] S2,
    output logic [W_DADO-1:0] S3,
    output logic [W_DADO-1:0] S4,
    output logic [W_DADO-1:0] S5,
    output logic [W_DADO-1:0] S6,
    output logic [W_DADO-1:0] S7,
    output logic [N_CANAIS-1:0] NOVO,
    output logic              FRAME_OK,
    output logic              ERRO,
    output logic [W_CONT-1:0] CONT_QUADRO
);

    estado_t             estado_r, estado_s;
    logic [W_ID-1:0]     esperado_r, esperado_s;
    logic [N_CANAIS-1:0] novo_r, novo_s;
    logic                frame_ok_r, frame_ok_s;
    logic                erro_r, erro_s;
    logic [W_CONT-1:0]   cont_r, cont_s;
    logic                aceita_s;
    logic                erro_evt_s;
    logic [N_CANAIS-1:0] sel_s;
    logic [N_CANAIS-1:0] novo_mais_s;
    logic [W_DADO-1:0]   s_r [N_CANAIS];

    // Next-state decision: accept/reject the incoming nibble, detect errors and frame end.
    always_comb begin
        estado_s    = estado_r;
        esperado_s  = esperado_r;
        novo_s      = novo_r;
        frame_ok_s  = 1'b0;
        cont_s      = cont_r;
        aceita_s    = 1'b0;
        erro_evt_s  = 1'b0;
        sel_s       = id_onehot(ID);
        novo_mais_s = novo_r | sel_s;

        if (VALID) begin
            case (estado_r)
                IDLE: begin
                    if (SEQ_CHECK && (ID != ID_ZERO)) begin
                        // A frame must open with channel 0; drop the nibble.
                        erro_evt_s = 1'b1;
                    end else begin
                        aceita_s   = 1'b1;
                        novo_s     = novo_mais_s;
                        esperado_s = ID + ID_UM;
                        estado_s   = COLLECT;
                    end
                end
                COLLECT: begin
                    if (SEQ_CHECK && (ID != esperado_r)) begin
                        // Out-of-order tag aborts the partial frame; registers keep old data.
                        erro_evt_s = 1'b1;
                        novo_s     = NOVO_VAZIO;
                        estado_s   = IDLE;
                    end else if (!SEQ_CHECK && ((novo_r & sel_s) != NOVO_VAZIO)) begin
                        // Overrun: the newer nibble wins but the frame keeps going.
                        aceita_s   = 1'b1;
                        erro_evt_s = 1'b1;
                    end else begin
                        aceita_s   = 1'b1;
                        novo_s     = novo_mais_s;
                        esperado_s = esperado_r + ID_UM;
                    end
                end
                default: begin
                    estado_s = IDLE;
                    novo_s   = NOVO_VAZIO;
                end
            endcase

            if (aceita_s && (novo_s == NOVO_CHEIO)) begin
                novo_s     = NOVO_VAZIO;
                frame_ok_s = 1'b1;
                cont_s     = cont_r + CONT_UM;
                estado_s   = IDLE;
            end else begin
                frame_ok_s = 1'b0;
            end
        end else begin
            estado_s = estado_r;
        end

        // A fresh error beats a simultaneous clear request.
        erro_s = erro_evt_s | (erro_r & ~CLR_ERRO);
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_r   <= IDLE;
            esperado_r <= ID_ZERO;
            novo_r     <= NOVO_VAZIO;
            frame_ok_r <= 1'b0;
            erro_r     <= 1'b0;
            cont_r     <= {W_CONT{1'b0}};
        end else begin
            estado_r   <= estado_s;
            esperado_r <= esperado_s;
            novo_r     <= novo_s;
            frame_ok_r <= frame_ok_s;
            erro_r     <= erro_s;
            cont_r     <= cont_s;
        end
    end

    genvar n;
    generate
        for (n = 0; n < N_CANAIS; n++) begin : g_canal
            tdm_canal_reg u_canal (
                .clk   (clk),
                .reset (reset),
                .load  (aceita_s && sel_s[n]),
                .d     (ENTRADA),
                .q     (s_r[n])
            );
        end
    endgenerate

    assign S0          = s_r[0];
    assign S1          = s_r[1];
    assign S2          = s_r[2];
    assign S3          = s_r[3];
    assign S4          = s_r[4];
    assign S5          = s_r[5];
    assign S6          = s_r[6];
    assign S7          = s_r[7];
    assign NOVO        = novo_r;
    assign FRAME_OK    = frame_ok_r;
    assign ERRO        = erro_r;
    assign CONT_QUADRO = cont_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: one instance with ordering checks off (index 0)
// and one with ordering checks on (index 1), both fed the same stimulus and compared
// every cycle against a frame-level reference model.
module tb_tdm_demux;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] entrada;
    logic [2:0] id;
    logic       valid;
    logic       clr_erro;

    logic [3:0] so [2][8];
    logic [7:0] novo_o [2];
    logic [7:0] cont_o [2];
    logic       fok_o [2];
    logic       erro_o [2];

    // Reference model state, per instance.
    int  m_s [2][8];
    bit  m_got [2][8];
    int  m_cnt [2];
    bit  m_err [2];
    int  m_frames [2];
    bit  m_fok [2];

    int  total = 0;
    int  bad   = 0;
    int  fok_seen [2];
    string nm [2] = '{"livre", "seq"};

    // Free-running clock.
    always #5 clk = ~clk;

    tdm_demux #(.SEQ_CHECK(1'b0)) dut_livre (
        .clk(clk), .reset(reset), .ENTRADA(entrada), .ID(id), .VALID(valid), .CLR_ERRO(clr_erro),
        .S0(so[0][0]), .S1(so[0][1]), .S2(so[0][2]), .S3(so[0][3]),
        .S4(so[0][4]), .S5(so[0][5]), .S6(so[0][6]), .S7(so[0][7]),
        .NOVO(novo_o[0]), .FRAME_OK(fok_o[0]), .ERRO(erro_o[0]), .CONT_QUADRO(cont_o[0])
    );

    tdm_demux #(.SEQ_CHECK(1'b1)) dut_seq (
        .clk(clk), .reset(reset), .ENTRADA(entrada), .ID(id), .VALID(valid), .CLR_ERRO(clr_erro),
        .S0(so[1][0]), .S1(so[1][1]), .S2(so[1][2]), .S3(so[1][3]),
        .S4(so[1][4]), .S5(so[1][5]), .S6(so[1][6]), .S7(so[1][7]),
        .NOVO(novo_o[1]), .FRAME_OK(fok_o[1]), .ERRO(erro_o[1]), .CONT_QUADRO(cont_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 8; k++) begin
                m_s[m][k]   = 0;
                m_got[m][k] = 1'b0;
            end
            m_cnt[m]    = 0;
            m_err[m]    = 1'b0;
            m_frames[m] = 0;
            m_fok[m]    = 1'b0;
        end
    endtask

    task automatic model_clear_frame(input int m);
        for (int k = 0; k < 8; k++) m_got[m][k] = 1'b0;
        m_cnt[m] = 0;
    endtask

    // A fresh channel for this frame: store it and close the frame once all eight are in.
    task automatic model_write(input int m, input int ch, input int d);
        m_s[m][ch]   = d;
        m_got[m][ch] = 1'b1;
        m_cnt[m]++;
        if (m_cnt[m] == 8) begin
            model_clear_frame(m);
            m_fok[m]    = 1'b1;
            m_frames[m] = (m_frames[m] + 1) % 256;
        end
    endtask

    // One clock edge of both receivers, from the behavioural rules.
    task automatic model_step(input bit v, input int ch, input int d, input bit c);
        for (int m = 0; m < 2; m++) begin
            bit ev;
            ev       = 1'b0;
            m_fok[m] = 1'b0;
            if (v) begin
                if (m == 1) begin
                    // In-order mode: the next tag must equal the number already received.
                    if (ch == m_cnt[m]) model_write(m, ch, d);
                    else begin
                        ev = 1'b1;
                        model_clear_frame(m);
                    end
                end else begin
                    if (m_got[m][ch]) begin
                        m_s[m][ch] = d;
                        ev = 1'b1;
                    end else begin
                        model_write(m, ch, d);
                    end
                end
            end
            m_err[m] = ev | (m_err[m] & !c);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [31:0] os, es;
            logic [7:0]  en;
            for (int k = 0; k < 8; k++) begin
                os[4*k +: 4] = so[m][k];
                es[4*k +: 4] = 4'(m_s[m][k]);
                en[k]        = m_got[m][k];
            end
            if (fok_o[m] === 1'b1) fok_seen[m]++;
            chk({"s_", nm[m]},    os, es);
            chk({"novo_", nm[m]}, {24'd0, novo_o[m]}, {24'd0, en});
            chk({"fok_", nm[m]},  {31'd0, fok_o[m]}, {31'd0, m_fok[m]});
            chk({"erro_", nm[m]}, {31'd0, erro_o[m]}, {31'd0, m_err[m]});
            chk({"cont_", nm[m]}, {24'd0, cont_o[m]}, 32'(m_frames[m]));
        end
    endtask

    task automatic step(input bit v, input int ch, input int d, input bit c);
        @(negedge clk);
        valid    = v;
        id       = 3'(ch);
        entrada  = 4'(d);
        clr_erro = c;
        @(posedge clk);
        model_step(v, ch, d, c);
        #1;
        check_all();
    endtask

    // Pulse reset between clock edges and confirm outputs clear without an edge.
    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        valid    = 1'b0;
        id       = 3'd0;
        entrada  = 4'd0;
        clr_erro = 1'b0;
        fok_seen[0] = 0;
        fok_seen[1] = 0;
        model_reset();

        // Full in-order frame, data = ID + 8.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, i, i + 8, 1'b0);
        chk("frame1_s7", {28'd0, so[1][7]}, 32'hF);
        chk("frame1_fok", {31'd0, fok_o[1]}, 32'd1);
        step(1'b0, 0, 0, 1'b0);
        chk("frame1_cont", {24'd0, cont_o[1]}, 32'd1);

        // Skipped tag 2 in ordered mode, then clear the flag.
        for (int i = 0; i < 3; i++) step(1'b1, (i == 2) ? 3 : i, $urandom_range(15, 0), 1'b0);
        chk("skip_erro", {31'd0, erro_o[1]}, 32'd1);
        chk("skip_s3", {28'd0, so[1][3]}, 32'hB);
        step(1'b0, 0, 0, 1'b1);
        chk("skip_clr", {31'd0, erro_o[1]}, 32'd0);

        // Overrun in unordered mode: tags 5,2,5 with data 1,2,3.
        do_reset();
        step(1'b1, 5, 1, 1'b0);
        step(1'b1, 2, 2, 1'b0);
        step(1'b1, 5, 3, 1'b0);
        chk("ovr_s5", {28'd0, so[0][5]}, 32'd3);
        chk("ovr_novo", {24'd0, novo_o[0]}, 32'h24);

        // Reset in the middle of a frame, then a clean full frame.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, i, $urandom_range(15, 0), 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, i, $urandom_range(15, 0), 1'b0);
        chk("post_rst_cont", {24'd0, cont_o[0]}, 32'd1);

        // 256 back-to-back frames wrap the counter.
        do_reset();
        fok_seen[0] = 0;
        fok_seen[1] = 0;
        for (int f = 0; f < 256; f++)
            for (int i = 0; i < 8; i++) step(1'b1, i, $urandom_range(15, 0), 1'b0);
        chk("wrap_cont", {24'd0, cont_o[1]}, 32'd0);
        chk("wrap_pulses_livre", 32'(fok_seen[0]), 32'd256);
        chk("wrap_pulses_seq", 32'(fok_seen[1]), 32'd256);

        // Clear request coinciding with a new ordering error.
        step(1'b1, 3, 4, 1'b0);
        step(1'b1, 5, 6, 1'b1);
        chk("clr_vs_err", {31'd0, erro_o[1]}, 32'd1);

        // Randomised traffic, mostly in-order tags for the ordered instance.
        for (int n = 0; n < 800; n++) begin
            int ch;
            if ($urandom_range(99, 0) == 0) do_reset();
            ch = ($urandom_range(3, 0) != 0) ? (m_cnt[1] % 8) : $urandom_range(7, 0);
            step($urandom_range(3, 0) != 0, ch, $urandom_range(15, 0), $urandom_range(7, 0) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
